// File: rtl/result_tx_pkg.sv
// Shared types and constants for the result UART transmitter.
// RESULT_TX_CHECKSUM_EN appends a modulo-256 checksum byte to every frame.
package result_tx_pkg;

   typedef enum logic {
      IDLE,
      SEND
   } frm_state_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } ser_state_t;

   localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
   localparam int         NBYTES_BASE    = 7;

`ifdef RESULT_TX_CHECKSUM_EN
   localparam int NBYTES = NBYTES_BASE + 1;
`else
   localparam int NBYTES = NBYTES_BASE;
`endif

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser with a valid/ready input; one byte per transfer.
// Frame length does not depend on RESULT_TX_CHECKSUM_EN; that macro only affects the framer.
module uart_tx_byte
   import result_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx,
   output logic       byte_done
);

   localparam int             BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   ser_state_t       state_q;
   logic [BW-1:0]    baud_q;
   logic [BW-1:0]    baud_d;
   logic [2:0]       bit_q;
   logic [7:0]       shift_q;
   logic             tx_q;
   logic             bit_end;

   // Handshake: a byte transfers on any edge where valid && ready; ready is high
   // only in S_IDLE, and the start bit is driven from that same edge.
   assign ready     = (state_q == S_IDLE);
   assign bit_end   = (baud_q == BAUD_LAST);
   assign baud_d    = (state_q == S_IDLE || bit_end) ? '0 : baud_q + 1'b1;
   // Combinational so the framer can finish on the very edge the stop bit ends.
   assign byte_done = (state_q == S_STOP) && bit_end;
   assign tx        = tx_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         baud_q <= baud_d;
         case (state_q)
            S_IDLE: begin
               if (valid) begin
                  shift_q <= data;
                  tx_q    <= 1'b0;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  tx_q    <= shift_q[0];
                  bit_q   <= '0;
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     shift_q <= {1'b0, shift_q[7:1]};
                     tx_q    <= shift_q[1];
                     bit_q   <= bit_q + 1'b1;
                  end
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/result_uart_tx.sv
// Latches one lowest/highest/hitvector result per flashin strobe and sends it as a UART packet.
// RESULT_TX_CHECKSUM_EN adds a trailing checksum byte (sum of the six payload bytes).
module result_uart_tx
   import result_tx_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 868,
   parameter logic [7:0] HEADER       = DEFAULT_HEADER
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flashin,
   input  logic [15:0] lowest,
   input  logic [15:0] highest,
   input  logic [15:0] hitvector,
   output logic        tx,
   output logic        busy,
   output logic        done,
   output logic        overrun
);

   localparam logic [3:0] NB_IDX = 4'(NBYTES);

   frm_state_t  state_q;
   logic [3:0]  idx_q;
   logic [15:0] low_q;
   logic [15:0] high_q;
   logic [15:0] hit_q;
   logic        busy_q;
   logic        done_q;
   logic        overrun_q;

   logic        valid;
   logic        ready;
   logic        byte_done;
   logic [7:0]  byte_d;

   assign valid = (state_q == SEND) && (idx_q < NB_IDX);

`ifdef RESULT_TX_CHECKSUM_EN
   logic [7:0] cks;
   assign cks = low_q[7:0] + low_q[15:8] + high_q[7:0] + high_q[15:8]
              + hit_q[7:0] + hit_q[15:8];
`endif

   always_comb begin
      byte_d = HEADER;
      case (idx_q)
         4'd1:    byte_d = low_q[7:0];
         4'd2:    byte_d = low_q[15:8];
         4'd3:    byte_d = high_q[7:0];
         4'd4:    byte_d = high_q[15:8];
         4'd5:    byte_d = hit_q[7:0];
         4'd6:    byte_d = hit_q[15:8];
`ifdef RESULT_TX_CHECKSUM_EN
         4'd7:    byte_d = cks;
`endif
         default: byte_d = HEADER;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         low_q     <= '0;
         high_q    <= '0;
         hit_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (flashin) begin
                  low_q   <= lowest;
                  high_q  <= highest;
                  hit_q   <= hitvector;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SEND;
               end
            end
            SEND: begin
               // A strobe during a frame is reported and dropped; the frame continues.
               if (flashin) overrun_q <= 1'b1;
               if (valid && ready) idx_q <= idx_q + 1'b1;
               if (byte_done && !valid) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_ser (
      .clock     (clock),
      .reset     (reset),
      .data      (byte_d),
      .valid     (valid),
      .ready     (ready),
      .tx        (tx),
      .byte_done (byte_done)
   );

   assign busy    = busy_q;
   assign done    = done_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx at CLKS_PER_BIT=4; frame length follows RESULT_TX_CHECKSUM_EN.
module tb_result_uart_tx;

   localparam int CPB       = 4;
   localparam int BYTE_CLKS = 10 * CPB + 1;
`ifdef RESULT_TX_CHECKSUM_EN
   localparam int NB = 8;
`else
   localparam int NB = 7;
`endif

   logic        clock     = 1'b0;
   logic        reset     = 1'b0;
   logic        flashin   = 1'b0;
   logic [15:0] lowest    = '0;
   logic [15:0] highest   = '0;
   logic [15:0] hitvector = '0;
   logic        tx;
   logic        busy;
   logic        done;
   logic        overrun;

   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int ovr_cnt  = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   logic       rx_stop_q[$];
   int         rx_start_q[$];
   logic [7:0] exp_cks;

   result_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .HEADER      (8'hA5)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .flashin   (flashin),
      .lowest    (lowest),
      .highest   (highest),
      .hitvector (hitvector),
      .tx        (tx),
      .busy      (busy),
      .done      (done),
      .overrun   (overrun)
   );

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- monitors ----------------
   always @(negedge clock) begin
      if (done === 1'b1)    done_cnt++;
      if (overrun === 1'b1) ovr_cnt++;
   end

   // Decodes tx mid-bit; start edge recorded as the edge count where tx first reads low.
   initial begin : rx_mon
      logic [7:0] b;
      int         s;
      forever begin
         @(negedge clock);
         if (tx === 1'b0) begin
            s = cyc;
            b = '0;
            repeat (2) @(negedge clock);
            for (int i = 0; i < 8; i++) begin
               repeat (4) @(negedge clock);
               b[i] = tx;
            end
            repeat (4) @(negedge clock);
            rx_stop_q.push_back(tx);
            rx_q.push_back(b);
            rx_start_q.push_back(s);
         end
      end
   end

   // ---------------- driver / checker tasks ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_flash(input logic [15:0] lo, input logic [15:0] hi,
                              input logic [15:0] hv, output int cap);
      lowest    = lo;
      highest   = hi;
      hitvector = hv;
      flashin   = 1'b1;
      cap       = cyc + 1;
      @(negedge clock);
      flashin   = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int dcyc);
      int n;
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clock);
         n++;
      end
      check("done_timeout", 32'(done === 1'b1), 32'd1);
      dcyc = cyc;
   endtask

   task automatic exp_frame(input logic [15:0] lo, input logic [15:0] hi,
                            input logic [15:0] hv, input logic [7:0] cks);
      exp_q.push_back(8'hA5);
      exp_q.push_back(lo[7:0]);
      exp_q.push_back(lo[15:8]);
      exp_q.push_back(hi[7:0]);
      exp_q.push_back(hi[15:8]);
      exp_q.push_back(hv[7:0]);
      exp_q.push_back(hv[15:8]);
      exp_cks = cks;
`ifdef RESULT_TX_CHECKSUM_EN
      exp_q.push_back(exp_cks);
`endif
   endtask

   task automatic check_frame(input string tag, input int cap);
      logic [7:0] got;
      logic       stp;
      int         s;
      int         exp_s;
      check({tag, "_nbytes"}, 32'(rx_q.size()), 32'(NB));
      exp_s = cap + 1;
      for (int k = 0; k < NB; k++) begin
         if (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            stp = rx_stop_q.pop_front();
            s   = rx_start_q.pop_front();
         end else begin
            got = 'x;
            stp = 1'bx;
            s   = -1;
         end
         check($sformatf("%s_byte%0d", tag, k), 32'(got), 32'(exp_q.pop_front()));
         check($sformatf("%s_stop%0d", tag, k), 32'(stp), 32'd1);
         check($sformatf("%s_start%0d", tag, k), s, exp_s);
         exp_s = exp_s + BYTE_CLKS;
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int cap;
      int cap2;
      int dcyc;
      int ovr0;
      int dc0;

      reset = 1'b0;
      tick(3);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_overrun", overrun, 0);
      reset = 1'b1;
      tick(2);

      // Basic frame: A5 34 12 CD AB FF 00 [BD]
      exp_frame(16'h1234, 16'hABCD, 16'h00FF, 8'hBD);
      pulse_flash(16'h1234, 16'hABCD, 16'h00FF, cap);
      check("t1_busy", busy, 1);
      wait_done(600, dcyc);
      check("t1_done_time", dcyc - cap - 1, NB * BYTE_CLKS - 1);
      check_frame("t1", cap);
      tick(1);
      check("t1_done_width", done, 0);
      check("t1_busy_clear", busy, 0);
      tick(3);

      // Inputs change one cycle after capture; frame must not change.
      exp_frame(16'h1234, 16'hABCD, 16'h00FF, 8'hBD);
      pulse_flash(16'h1234, 16'hABCD, 16'h00FF, cap);
      lowest    = 16'hFFFF;
      highest   = 16'hFFFF;
      hitvector = 16'hFFFF;
      wait_done(600, dcyc);
      check("t2_done_time", dcyc - cap - 1, NB * BYTE_CLKS - 1);
      check_frame("t2", cap);
      tick(3);

      // Overrun 50 clocks into the frame.
      exp_frame(16'h1234, 16'hABCD, 16'h00FF, 8'hBD);
      ovr0 = ovr_cnt;
      pulse_flash(16'h1234, 16'hABCD, 16'h00FF, cap);
      tick(49);
      flashin = 1'b1;
      tick(1);
      flashin = 1'b0;
      check("t3_overrun_hi", overrun, 1);
      check("t3_busy_kept", busy, 1);
      tick(1);
      check("t3_overrun_lo", overrun, 0);
      wait_done(600, dcyc);
      check("t3_done_time", dcyc - cap - 1, NB * BYTE_CLKS - 1);
      check_frame("t3", cap);
      tick(60);
      check("t3_no_second_frame", 32'(rx_q.size()), 0);
      check("t3_idle_busy", busy, 0);
      check("t3_overrun_count", ovr_cnt - ovr0, 1);

      // Back-to-back: second strobe in the done cycle; second frame has checksum wrap FA.
      exp_frame(16'h1234, 16'hABCD, 16'h00FF, 8'hBD);
      pulse_flash(16'h1234, 16'hABCD, 16'h00FF, cap);
      wait_done(600, dcyc);
      check("t4a_done_time", dcyc - cap - 1, NB * BYTE_CLKS - 1);
      check_frame("t4a", cap);
      exp_frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 8'hFA);
      pulse_flash(16'hFFFF, 16'hFFFF, 16'hFFFF, cap2);
      check("t4_no_overrun", overrun, 0);
      check("t4_busy_again", busy, 1);
      wait_done(600, dcyc);
      check("t4b_done_time", dcyc - cap2 - 1, NB * BYTE_CLKS - 1);
      check_frame("t4b", cap2);
      tick(3);

      // Reset during byte 3 data bits aborts the frame.
      pulse_flash(16'h1234, 16'hABCD, 16'h00FF, cap);
      tick(3 * BYTE_CLKS + 10);
      dc0   = done_cnt;
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      check("t5_tx_idle", tx, 1);
      check("t5_busy_clear", busy, 0);
      tick(60);
      check("t5_no_done", done_cnt - dc0, 0);
      check("t5_still_idle", busy, 0);
      rx_q.delete();
      rx_stop_q.delete();
      rx_start_q.delete();
      exp_frame(16'h1234, 16'hABCD, 16'h00FF, 8'hBD);
      pulse_flash(16'h1234, 16'hABCD, 16'h00FF, cap);
      wait_done(600, dcyc);
      check("t5_done_time", dcyc - cap - 1, NB * BYTE_CLKS - 1);
      check_frame("t5", cap);

      // ---------------- final report ----------------
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
